// File: rtl/gated_sync_stage_pkg.sv
// ============================================================================
// gated_sync_pkg : shared FSM state type and counter widths for gated_sync_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package gated_sync_pkg;

    localparam int GS_DEB_W   = 8;
    localparam int GS_DRAIN_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } gs_state_t;

    function automatic logic gs_drives_en(input gs_state_t s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gated_sync_stage_if.sv
// ============================================================================
// gated_sync_stage_if : request/data inputs and conditioned outputs of the stage
// Revision: 1.0
// ============================================================================
`default_nettype none

interface gated_sync_stage_if;

    logic en_req;
    logic data_in;
    logic clk_en;
    logic gclk;
    logic data_out;
    logic data_vld;
    logic busy;

    modport master (
        output en_req,
        output data_in,
        input  clk_en,
        input  gclk,
        input  data_out,
        input  data_vld,
        input  busy
    );

    modport slave (
        input  en_req,
        input  data_in,
        output clk_en,
        output gclk,
        output data_out,
        output data_vld,
        output busy
    );

endinterface

`default_nettype wire

// File: rtl/gated_sync_stage_sync_bit.sv
// ============================================================================
// sync_bit : SYNC_STAGES-deep flop chain bringing one async bit into clk domain
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic d,
    output logic      q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/gated_sync_stage.sv
// ============================================================================
// gated_sync_stage : synchronise/debounce enable, produce registered clk_en and
// data/valid; latch-based clock gate on gclk when GATED_SYNC_STAGE_ICG_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gated_sync_stage
    import gated_sync_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEB_LIMIT    = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    gated_sync_stage_if.slave  bus
);

    localparam logic [GS_DEB_W-1:0]   c_DEB_MAX   = GS_DEB_W'(DEB_LIMIT - 1);
    localparam logic [GS_DEB_W-1:0]   c_DEB_ONE   = GS_DEB_W'(1);
    localparam logic [GS_DRAIN_W-1:0] c_DRAIN_MAX = GS_DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [GS_DRAIN_W-1:0] c_DRAIN_ONE = GS_DRAIN_W'(1);

    logic                  w_en_s;
    logic                  w_d_s;
    gs_state_t             r_state;
    gs_state_t             w_next;
    logic                  w_accept;
    logic [GS_DEB_W-1:0]   r_deb_cnt;
    logic [GS_DRAIN_W-1:0] r_drain_cnt;
    logic                  r_clk_en;
    logic                  r_data_out;
    logic                  r_data_vld;
    logic                  r_busy;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.en_req),
        .q     (w_en_s)
    );

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.data_in),
        .q     (w_d_s)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = (r_state == ARM) || (r_state == RUN);
        case (r_state)
            IDLE:    if (w_en_s && (r_deb_cnt == c_DEB_MAX))  w_next = ARM;
            ARM:     w_next = RUN;
            RUN:     if (!w_en_s && (r_deb_cnt == c_DEB_MAX)) w_next = DRAIN;
            DRAIN:   if (r_drain_cnt == c_DRAIN_MAX)          w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Debounce restarts on every state change and is frozen through DRAIN,
    // so an early re-request never shortcuts DRAIN back to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_cnt <= '0;
        end else if ((w_next != r_state) || (r_state == DRAIN) || (w_en_s == w_accept)) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt != c_DEB_MAX) begin
            r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
        end else if (r_state == DRAIN) begin
            r_drain_cnt <= r_drain_cnt + c_DRAIN_ONE;
        end else begin
            r_drain_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_en   <= 1'b0;
            r_data_out <= 1'b0;
            r_data_vld <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_clk_en   <= gs_drives_en(w_next);
            r_data_vld <= (w_next == RUN);
            r_busy     <= (w_next != IDLE);
            if ((r_state == ARM) || (r_state == RUN)) begin
                r_data_out <= w_d_s;
            end
        end
    end

    assign bus.clk_en   = r_clk_en;
    assign bus.data_out = r_data_out;
    assign bus.data_vld = r_data_vld;
    assign bus.busy     = r_busy;

`ifdef GATED_SYNC_STAGE_ICG_EN
    // Enable is captured while clk is low so gclk can only change on clk rise.
    logic r_en_lat;

    always_latch begin
        if (!clk) begin
            r_en_lat <= r_clk_en;
        end
    end

    assign bus.gclk = clk & r_en_lat;
`else
    assign bus.gclk = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gated_sync_stage.sv
// ============================================================================
// tb_gated_sync_stage : directed self-checking bench for gated_sync_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gated_sync_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    gated_sync_stage_if bus ();

    gated_sync_stage #(
        .SYNC_STAGES  (2),
        .DEB_LIMIT    (8),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_bit({tag, ".clk_en"},   bus.clk_en,   1'b0);
        check_bit({tag, ".gclk"},     bus.gclk,     1'b0);
        check_bit({tag, ".data_vld"}, bus.data_vld, 1'b0);
        check_bit({tag, ".busy"},     bus.busy,     1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        bus.en_req  = 1'b0;
        bus.data_in = 1'b0;

        #2;
        check_quiet("reset");
        check_bit("reset.data_out", bus.data_out, 1'b0);

        tick(3);
        rst_n = 1'b1;

        // Idle with inputs low
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check_quiet("idle");
            check_bit("idle.data_out", bus.data_out, 1'b0);
        end

        // Short enable pulse: 5 cycles of en_s never reaches the debounce limit
        bus.en_req = 1'b1;
        tick(5);
        bus.en_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_quiet("glitch");
        end

        // Enable on: en_s high 2 edges later, ARM 8 after that, RUN outputs one later
        bus.en_req = 1'b1;
        tick(9);
        check_bit("on.pre_busy",   bus.busy,   1'b0);
        check_bit("on.pre_clk_en", bus.clk_en, 1'b0);
        tick(1);
        check_bit("on.arm_busy",     bus.busy,     1'b1);
        check_bit("on.arm_clk_en",   bus.clk_en,   1'b0);
        check_bit("on.arm_data_vld", bus.data_vld, 1'b0);
        tick(1);
        check_bit("on.run_clk_en",   bus.clk_en,   1'b1);
        check_bit("on.run_data_vld", bus.data_vld, 1'b1);
        check_bit("on.run_data_out", bus.data_out, 1'b0);

        // Data 1,0,1 reappears three edges later
        bus.data_in = 1'b1;
        tick(1);
        bus.data_in = 1'b0;
        tick(1);
        check_bit("data.not_yet", bus.data_out, 1'b0);
        bus.data_in = 1'b1;
        tick(1);
        check_bit("data.bit0", bus.data_out, 1'b1);
        bus.data_in = 1'b1;
        tick(1);
        check_bit("data.bit1", bus.data_out, 1'b0);
        tick(1);
        check_bit("data.bit2", bus.data_out, 1'b1);
        check_bit("data.vld",  bus.data_vld, 1'b1);
        tick(3);

        // Enable off: DRAIN 10 edges after release, clk_en low two edges later
        bus.en_req = 1'b0;
        tick(9);
        check_bit("off.run_clk_en",   bus.clk_en,   1'b1);
        check_bit("off.run_data_vld", bus.data_vld, 1'b1);
        tick(1);
        bus.data_in = 1'b0;
        check_bit("off.drain_vld",    bus.data_vld, 1'b0);
        check_bit("off.drain_clk_en", bus.clk_en,   1'b1);
        check_bit("off.drain_busy",   bus.busy,     1'b1);
        check_bit("off.drain_hold",   bus.data_out, 1'b1);
        tick(1);
        check_bit("off.drain2_clk_en", bus.clk_en, 1'b1);
        tick(1);
        check_bit("off.idle_clk_en", bus.clk_en,   1'b0);
        check_bit("off.idle_busy",   bus.busy,     1'b0);
        check_bit("off.idle_hold",   bus.data_out, 1'b1);

        // Re-request during DRAIN: drain completes, debounce restarts in IDLE
        bus.en_req = 1'b1;
        tick(11);
        check_bit("redrain.run", bus.clk_en, 1'b1);
        bus.en_req = 1'b0;
        tick(8);
        bus.en_req = 1'b1;
        tick(2);
        check_bit("redrain.drain_busy", bus.busy,     1'b1);
        check_bit("redrain.drain_vld",  bus.data_vld, 1'b0);
        check_bit("redrain.drain_en",   bus.clk_en,   1'b1);
        tick(1);
        check_bit("redrain.drain2_en", bus.clk_en, 1'b1);
        tick(1);
        check_bit("redrain.idle_en",   bus.clk_en, 1'b0);
        check_bit("redrain.idle_busy", bus.busy,   1'b0);
        tick(7);
        check_bit("redrain.deb_busy", bus.busy, 1'b0);
        tick(1);
        check_bit("redrain.arm_busy", bus.busy, 1'b1);
        tick(1);
        check_bit("redrain.run_en",  bus.clk_en,   1'b1);
        check_bit("redrain.run_vld", bus.data_vld, 1'b1);

        // Async reset mid-RUN with data_out at 1
        bus.data_in = 1'b1;
        tick(4);
        check_bit("areset.pre_data", bus.data_out, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_bit("areset.clk_en",   bus.clk_en,   1'b0);
        check_bit("areset.data_out", bus.data_out, 1'b0);
        check_bit("areset.data_vld", bus.data_vld, 1'b0);
        check_bit("areset.busy",     bus.busy,     1'b0);
        bus.en_req  = 1'b0;
        bus.data_in = 1'b0;
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_quiet("post_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gated_sync_stage.md
# gated_sync_stage

Input conditioning stage that sits directly upstream of the register stage (`myreg`) and replaces the raw combinational `en & clk` gating in the top level. It synchronises the asynchronous enable request and serial data input into the `clk` domain and debounces the enable. A four-state FSM then produces a clean, registered clock-enable with a defined drain window, plus a registered data/valid pair for the downstream register.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of each input synchroniser; legal range 2..4.
- `DEB_LIMIT`, 8: consecutive stable cycles required to accept an enable change; legal range 2..255.
- `DRAIN_CYCLES`, 2: cycles `clk_en` stays high after enable release; legal range 1..15.

Ports:
- `clk`, in, 1: single clock; all state is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en_req`, in, 1: asynchronous enable request (e.g. `en1`).
- `data_in`, in, 1: asynchronous data (e.g. `data1`).
- `clk_en`, out, 1: registered enable to the downstream stage.
- `gclk`, out, 1: gated clock; only meaningful with the macro (see Configuration).
- `data_out`, out, 1: registered synchronised data.
- `data_vld`, out, 1: `data_out` is valid this cycle.
- `busy`, out, 1: FSM is not in IDLE.

## Operation
- `en_s` and `d_s` are the last flops of `SYNC_STAGES`-deep synchronisers on `en_req` and `data_in`.
- `deb_cnt` is 8 bits wide and saturates at `DEB_LIMIT-1`.
  - It clears whenever `en_s` equals the level accepted for the current state.
  - Otherwise it increments.
- FSM states are IDLE, ARM, RUN and DRAIN.
- IDLE:
  - `clk_en`=0, `data_vld`=0.
  - A transition to ARM occurs when `en_s`=1 and `deb_cnt`==`DEB_LIMIT-1`.
  - Any `en_s`=0 cycle clears `deb_cnt`.
- ARM:
  - Lasts exactly one cycle and loads `data_out`←`d_s`.
  - Next state is RUN.
- RUN:
  - `clk_en`=1, `data_vld`=1, `data_out`←`d_s` every cycle.
  - A transition to DRAIN occurs when `en_s`=0 and `deb_cnt`==`DEB_LIMIT-1`.
  - Any `en_s`=1 cycle clears `deb_cnt`.
- DRAIN:
  - `clk_en`=1, `data_vld`=0, `data_out` holds.
  - `drain_cnt` counts 0..`DRAIN_CYCLES-1`, then the FSM returns to IDLE.
  - If `en_s`=1 during DRAIN, the drain is still completed. The FSM then returns to IDLE and debounce restarts from 0; it never goes DRAIN→RUN directly.
- `busy` = (state != IDLE).
- Reset mid-operation: all outputs and counters clear immediately and asynchronously, and the FSM goes to IDLE. Synchroniser flops reset to 0.

## Timing
- Reset values: `clk_en`=0, `gclk`=0, `data_out`=0, `data_vld`=0, `busy`=0.
- Input-to-`en_s` latency is `SYNC_STAGES` cycles.
- Enable-on latency:
  - `en_s` first high at cycle N gives state ARM at N+`DEB_LIMIT`.
  - `clk_en`/`data_vld` are high from N+`DEB_LIMIT`+1.
- Enable-off latency:
  - `en_s` first low at cycle M (in RUN) gives DRAIN at M+`DEB_LIMIT`.
  - `clk_en` stays high through M+`DEB_LIMIT`+`DRAIN_CYCLES`-1 and is low from M+`DEB_LIMIT`+`DRAIN_CYCLES`.
- Data path in RUN: `data_in` to `data_out` is `SYNC_STAGES`+1 cycles.
- A glitch on `en_s` shorter than `DEB_LIMIT` cycles produces no state change.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: `GATED_SYNC_STAGE_ICG_EN`.
- Defined:
  - A latch-based clock gate is instantiated.
  - The enable is latched while `clk` is low, giving `gclk` = `clk` & latched `clk_en`, which is glitch-free.
  - The downstream stage may be clocked by `gclk`.
- Undefined:
  - `gclk` is tied to 0.
  - The downstream stage runs on `clk` and uses `clk_en` as a synchronous enable.
  - No latch is present in the netlist.

## Structure
- Shared package `gated_sync_pkg`:
  - FSM state enum `gs_state_t` (IDLE=2'd0, ARM=2'd1, RUN=2'd2, DRAIN=2'd3).
  - `GS_DEB_W`=8.
  - `GS_DRAIN_W`=4.
- Sub-module `sync_bit`: parameterised `SYNC_STAGES` flop chain with async active-low reset, instantiated twice.
- The ICG latch is inline under the macro; there is no separate module.

## Test plan
All cases use default parameters unless stated.
- Reset release, inputs at 0 for 50 cycles -> all outputs 0, `busy`=0 throughout.
- `en_req` rises at cycle 10 and stays high -> `en_s` high at 12, ARM at 20, `clk_en`=1 and `data_vld`=1 from 21.
- `en_req` high for 5 cycles, then low -> no ARM, `clk_en` never asserts, `busy` stays 0.
- In RUN, toggle `data_in` 1,0,1 on consecutive cycles -> `data_out` reproduces 1,0,1 exactly 3 cycles later.
- `en_req` falls at cycle 100 in RUN -> DRAIN at 110, `data_vld`=0 from 110, `clk_en` low from 112, then IDLE.
- Assert `rst_n`=0 asynchronously mid-RUN -> `clk_en`, `data_out`, `data_vld` and `busy` go to 0 without waiting for a `clk` edge. With `GATED_SYNC_STAGE_ICG_EN` defined, `gclk` shows no pulse narrower than a half clock period.
